// File: rtl/fetch_ctrl_if.sv
// Bus bundle between the fetch controller and its environment:
// instruction-memory request/response, redirect input and decode-side buffer.
interface fetch_ctrl_if #(
    parameter int WIDTH   = 32,
    parameter int INSTR_W = 32
);
    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [WIDTH-1:0]   imem_req_addr;
    logic               imem_resp_valid;
    logic [INSTR_W-1:0] imem_resp_data;
    logic               redirect_valid;
    logic [WIDTH-1:0]   redirect_target;
    logic               inst_valid;
    logic               inst_ready;
    logic [INSTR_W-1:0] inst_data;
    logic [WIDTH-1:0]   inst_pc;

    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
               redirect_valid, redirect_target, inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
               redirect_valid, redirect_target, inst_ready
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch PC sequencer: single-outstanding instruction fetch, one-entry decode
// buffer, redirect handling with a drop flag for stale in-flight responses.
//
//  state | meaning
//  BOOT  | first cycle after reset, no request issued
//  REQ   | presenting a fetch request at pc, waiting for accept
//  WAIT  | one request outstanding, waiting for its response
module fetch_ctrl #(
    parameter int               WIDTH    = 32,
    parameter int               INSTR_W  = 32,
    parameter logic [WIDTH-1:0] RESET_PC = 32'hBFC00000
) (
    input  logic             clk,
    input  logic             rst,
    fetch_ctrl_if.master     bus,
    output logic [WIDTH-1:0] pc
);
    typedef enum logic [1:0] {BOOT, REQ, WAIT} state_t;

    state_t             state, state_n;
    logic [WIDTH-1:0]   pc_q, pc_n;
    logic [WIDTH-1:0]   inst_pc_q, inst_pc_n;
    logic [INSTR_W-1:0] inst_data_q, inst_data_n;
    logic               inst_valid_q, inst_valid_n;
    logic               drop_q, drop_n;
    logic               req_valid, accept;
    logic [WIDTH-1:0]   target;

    assign target    = bus.redirect_target & ~WIDTH'(3);
    assign req_valid = (state == REQ) && (!inst_valid_q || bus.inst_ready);
    assign accept    = req_valid && bus.imem_req_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= BOOT;
            pc_q         <= RESET_PC;
            drop_q       <= 1'b0;
            inst_valid_q <= 1'b0;
            inst_data_q  <= '0;
            inst_pc_q    <= '0;
        end else begin
            state        <= state_n;
            pc_q         <= pc_n;
            drop_q       <= drop_n;
            inst_valid_q <= inst_valid_n;
            inst_data_q  <= inst_data_n;
            inst_pc_q    <= inst_pc_n;
        end
    end

    always_comb begin
        state_n      = state;
        pc_n         = pc_q;
        drop_n       = drop_q;
        inst_valid_n = inst_valid_q;
        inst_data_n  = inst_data_q;
        inst_pc_n    = inst_pc_q;

        if (inst_valid_q && bus.inst_ready) inst_valid_n = 1'b0;

        case (state)
            BOOT: begin
                state_n = REQ;
                if (bus.redirect_valid) pc_n = target;
            end
            REQ: begin
                if (accept) begin
                    state_n = WAIT;
                    // request already left with the old pc, so its response is stale
                    if (bus.redirect_valid) begin
                        pc_n   = target;
                        drop_n = 1'b1;
                    end
                end else if (bus.redirect_valid) begin
                    pc_n = target;
                end
            end
            WAIT: begin
                if (bus.imem_resp_valid) begin
                    state_n = REQ;
                    drop_n  = 1'b0;
                    if (bus.redirect_valid) begin
                        pc_n = target;
                    end else if (!drop_q) begin
                        inst_data_n  = bus.imem_resp_data;
                        inst_pc_n    = pc_q;
                        inst_valid_n = 1'b1;
                        pc_n         = pc_q + WIDTH'(4);
                    end
                end else if (bus.redirect_valid) begin
                    pc_n   = target;
                    drop_n = 1'b1;
                end
            end
            default: state_n = BOOT;
        endcase

        if (bus.redirect_valid) inst_valid_n = 1'b0;
    end

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = pc_q;
    assign bus.inst_valid     = inst_valid_q;
    assign bus.inst_data      = inst_data_q;
    assign bus.inst_pc        = inst_pc_q;
    assign pc                 = pc_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a scoreboard of expected request addresses and
// delivered instructions, checked by a monitor as the DUT presents them.
module tb_fetch_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;

    fetch_ctrl_if #(.WIDTH(32), .INSTR_W(32)) bus ();

    fetch_ctrl #(.WIDTH(32), .INSTR_W(32), .RESET_PC(32'hBFC00000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master),
        .pc  (pc)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int acc_cnt = 0;
    int inst_cnt = 0;

    logic [31:0] req_q[$];
    logic [31:0] ipc_q[$];
    logic [31:0] idata_q[$];

    int  resp_lat = 1;
    bit  resp_en  = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    task automatic flag_fail(input string name);
        n_total++;
        $display("FAIL %s: event did not occur within budget", name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // delivered=0 for fetches whose response is expected to be discarded
    task automatic exp_fetch(input logic [31:0] a, input bit delivered);
        req_q.push_back(a);
        if (delivered) begin
            ipc_q.push_back(a);
            idata_q.push_back(~a);
        end
    endtask

    task automatic wait_acc(input int n);
        int b = 0;
        while (acc_cnt < n && b < 100) begin step(); b++; end
        if (acc_cnt < n) flag_fail("accept_timeout");
    endtask

    task automatic wait_inst(input int n);
        int b = 0;
        while (inst_cnt < n && b < 100) begin step(); b++; end
        if (inst_cnt < n) flag_fail("inst_timeout");
    endtask

    // monitor: compares everything the DUT hands out against the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.imem_req_valid && bus.imem_req_ready) begin
                    acc_cnt++;
                    if (req_q.size() == 0) flag_fail("unexpected_req");
                    else check("req_addr", bus.imem_req_addr, req_q.pop_front());
                end
                if (bus.inst_valid && bus.inst_ready) begin
                    inst_cnt++;
                    if (ipc_q.size() == 0) flag_fail("unexpected_inst");
                    else begin
                        check("inst_pc", bus.inst_pc, ipc_q.pop_front());
                        check("inst_data", bus.inst_data, idata_q.pop_front());
                    end
                end
            end
        end
    end

    // memory responder: answers resp_lat cycles after accept with ~addr
    bit          r_acc;
    bit          r_pend;
    int          r_cnt;
    logic [31:0] r_addr_s;
    logic [31:0] r_addr;
    initial begin
        r_pend = 1'b0;
        forever begin
            @(negedge clk);
            r_acc    = bus.imem_req_valid && bus.imem_req_ready && !rst;
            r_addr_s = bus.imem_req_addr;
            @(posedge clk);
            #1;
            if (resp_en) begin
                bus.imem_resp_valid = 1'b0;
                if (r_acc) begin
                    r_pend = 1'b1;
                    r_cnt  = resp_lat - 1;
                    r_addr = r_addr_s;
                end
                if (r_pend) begin
                    if (r_cnt == 0) begin
                        bus.imem_resp_valid = 1'b1;
                        bus.imem_resp_data  = ~r_addr;
                        r_pend = 1'b0;
                    end else begin
                        r_cnt--;
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = '0;
        bus.inst_ready      = 1'b0;

        // reset state
        #12;
        check("rst_pc", pc, 32'hBFC00000);
        check("rst_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
        check("rst_inst_valid", {31'b0, bus.inst_valid}, 32'd0);
        check("rst_inst_pc", bus.inst_pc, 32'd0);
        check("rst_inst_data", bus.inst_data, 32'd0);
        step();
        rst = 1'b0;
        check("boot_no_req", {31'b0, bus.imem_req_valid}, 32'd0);

        // 1: sequential fetch from the boot address
        exp_fetch(32'hBFC00000, 1);
        exp_fetch(32'hBFC00004, 1);
        exp_fetch(32'hBFC00008, 1);
        bus.inst_ready     = 1'b1;
        bus.imem_req_ready = 1'b1;
        wait_acc(3);
        bus.imem_req_ready = 1'b0;
        wait_inst(3);

        // 2: decode back-pressure blocks further requests
        exp_fetch(32'hBFC0000C, 1);
        exp_fetch(32'hBFC00010, 1);
        bus.inst_ready     = 1'b0;
        bus.imem_req_ready = 1'b1;
        wait_acc(4);
        step();
        for (int i = 0; i < 3; i++) begin
            check("stall_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
            check("stall_inst_pc", bus.inst_pc, 32'hBFC0000C);
            step();
        end
        bus.inst_ready = 1'b1;
        wait_acc(5);
        bus.imem_req_ready = 1'b0;
        wait_inst(5);

        // 3: redirect while waiting, stale response dropped
        exp_fetch(32'hBFC00014, 0);
        exp_fetch(32'h80000100, 1);
        resp_lat = 2;
        bus.imem_req_ready = 1'b1;
        wait_acc(6);
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h80000100;
        step();
        bus.redirect_valid = 1'b0;
        step();
        check("drop_inst_valid", {31'b0, bus.inst_valid}, 32'd0);
        check("redir_req_addr", bus.imem_req_addr, 32'h80000100);
        wait_acc(7);
        bus.imem_req_ready = 1'b0;
        wait_inst(6);

        // 4: redirect coincident with the response
        exp_fetch(32'h80000104, 0);
        exp_fetch(32'h80000200, 1);
        resp_lat = 1;
        bus.imem_req_ready = 1'b1;
        wait_acc(8);
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h80000200;
        step();
        bus.redirect_valid = 1'b0;
        check("coinc_inst_valid", {31'b0, bus.inst_valid}, 32'd0);
        check("coinc_req_addr", bus.imem_req_addr, 32'h80000200);
        wait_acc(9);
        bus.imem_req_ready = 1'b0;
        wait_inst(7);

        // 5: unaligned target is word-aligned; pc wraps past the top
        exp_fetch(32'h80000100, 1);
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h80000103;
        step();
        bus.redirect_valid = 1'b0;
        check("align_req_addr", bus.imem_req_addr, 32'h80000100);
        bus.imem_req_ready = 1'b1;
        wait_acc(10);
        bus.imem_req_ready = 1'b0;
        wait_inst(8);

        exp_fetch(32'hFFFFFFFC, 1);
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'hFFFFFFFC;
        step();
        bus.redirect_valid = 1'b0;
        bus.imem_req_ready = 1'b1;
        wait_acc(11);
        bus.imem_req_ready = 1'b0;
        wait_inst(9);
        check("wrap_pc", pc, 32'h00000000);
        check("wrap_req_addr", bus.imem_req_addr, 32'h00000000);

        // 6: asynchronous reset in WAIT, late response ignored
        exp_fetch(32'h00000000, 0);
        resp_en = 1'b0;
        bus.imem_req_ready = 1'b1;
        wait_acc(12);
        bus.imem_req_ready = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        check("arst_pc", pc, 32'hBFC00000);
        check("arst_inst_pc", bus.inst_pc, 32'd0);
        check("arst_inst_data", bus.inst_data, 32'd0);
        check("arst_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
        step();
        rst = 1'b0;
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = 32'hDEADBEEF;
        step();
        step();
        bus.imem_resp_valid = 1'b0;
        check("late_inst_valid", {31'b0, bus.inst_valid}, 32'd0);
        check("late_req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
        check("late_req_addr", bus.imem_req_addr, 32'hBFC00000);
        exp_fetch(32'hBFC00000, 1);
        resp_en = 1'b1;
        bus.imem_req_ready = 1'b1;
        wait_acc(13);
        bus.imem_req_ready = 1'b0;
        wait_inst(10);

        step();
        check("req_q_drained", req_q.size(), 32'd0);
        check("inst_q_drained", ipc_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
